// File: rtl/agc_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : agc_channel_scheduler
// Brief    : Round-robin AGC for NUM_CH inputs sharing one ADC and relay stage.
// Revision : 1.0 - initial release
// ============================================================================
module agc_channel_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW        = 256,
  parameter int OVER_TH       = 3941,
  parameter int LOW_TH        = 1791,
  parameter int HIGH_TH       = 3685,
  parameter int STABLE_N      = 3
) (
  input  logic                adc_clk,
  input  logic                rst,
  input  logic [11:0]         adc_data,
  input  logic                adc_valid,
  input  logic                enable,
  output logic [CH_W-1:0]     mux_sel,
  output logic [1:0]          gain_ctrl,
  output logic [2*NUM_CH-1:0] ch_gain,
  output logic [NUM_CH-1:0]   ch_stable,
  output logic                meas_valid,
  output logic [CH_W-1:0]     meas_ch,
  output logic [11:0]         meas_pp,
  output logic                busy
);

  localparam int                 C_SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int                 C_WIN_W    = $clog2(WINDOW + 1);
  localparam logic [C_SET_W-1:0] C_SET_LAST = C_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [C_WIN_W-1:0] C_WIN_LAST = C_WIN_W'(WINDOW - 1);
  localparam logic [11:0]        C_OVER_TH  = 12'(OVER_TH);
  localparam logic [11:0]        C_LOW_TH   = 12'(LOW_TH);
  localparam logic [11:0]        C_HIGH_TH  = 12'(HIGH_TH);
  localparam logic [CH_W-1:0]    C_LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [1:0]         C_STABLE_N = 2'(STABLE_N);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_DECIDE  = 3'd4,
    S_NEXT    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_W-1:0]    r_ptr;
  logic [1:0]         r_gain     [NUM_CH];
  logic [1:0]         r_stab_cnt [NUM_CH];
  logic [C_SET_W-1:0] r_settle_cnt;
  logic [C_WIN_W-1:0] r_samp_cnt;
  logic [11:0]        r_peak;
  logic [11:0]        r_valley;
  logic [CH_W-1:0]    r_mux_sel;
  logic [1:0]         r_gain_ctrl;
  logic               r_meas_valid;
  logic [CH_W-1:0]    r_meas_ch;
  logic [11:0]        r_meas_pp;

  logic [1:0]  w_cur_gain;
  logic [11:0] w_peak_nxt;
  logic [11:0] w_valley_nxt;
  logic        w_overload;
  logic        w_accept;
  logic        w_win_done;
  logic        w_settle_done;

  assign w_cur_gain    = r_gain[r_ptr];
  assign w_peak_nxt    = (adc_data > r_peak)   ? adc_data : r_peak;
  assign w_valley_nxt  = (adc_data < r_valley) ? adc_data : r_valley;
  // At gain 0 there is nothing left to back off, so clipping samples just count as data
  assign w_overload    = (r_state == S_MEASURE) && adc_valid &&
                         (adc_data >= C_OVER_TH) && (w_cur_gain != 2'd0);
  assign w_accept      = (r_state == S_MEASURE) && adc_valid && !w_overload;
  assign w_win_done    = w_accept && (r_samp_cnt == C_WIN_LAST);
  assign w_settle_done = (r_settle_cnt == C_SET_LAST);

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_state_nxt = S_SELECT;
      S_SELECT:  w_state_nxt = S_SETTLE;
      S_SETTLE:  if (w_settle_done) w_state_nxt = S_MEASURE;
      S_MEASURE: begin
        if (w_overload)      w_state_nxt = S_SELECT;
        else if (w_win_done) w_state_nxt = S_DECIDE;
      end
      S_DECIDE:  w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = enable ? S_SELECT : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_settle_cnt <= '0;
      r_samp_cnt   <= '0;
      r_peak       <= '0;
      r_valley     <= '0;
      r_mux_sel    <= '0;
      r_gain_ctrl  <= '0;
      r_meas_valid <= 1'b0;
      r_meas_ch    <= '0;
      r_meas_pp    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_gain[k]     <= '0;
        r_stab_cnt[k] <= '0;
      end
    end else begin
      r_meas_valid <= 1'b0;
      case (r_state)
        S_SELECT: begin
          r_mux_sel    <= r_ptr;
          r_gain_ctrl  <= w_cur_gain;
          r_settle_cnt <= '0;
        end
        S_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
          if (w_settle_done) begin
            r_peak     <= 12'h000;
            r_valley   <= 12'hFFF;
            r_samp_cnt <= '0;
          end
        end
        S_MEASURE: begin
          if (w_overload) begin
            r_gain[r_ptr]     <= w_cur_gain - 2'd1;
            r_stab_cnt[r_ptr] <= '0;
          end else if (w_accept) begin
            r_peak     <= w_peak_nxt;
            r_valley   <= w_valley_nxt;
            r_samp_cnt <= r_samp_cnt + 1'b1;
            // Result is registered here so the pulse lines up with the decide cycle
            if (w_win_done) begin
              r_meas_valid <= 1'b1;
              r_meas_ch    <= r_ptr;
              r_meas_pp    <= w_peak_nxt - w_valley_nxt;
            end
          end
        end
        S_DECIDE: begin
          if ((r_meas_pp > C_HIGH_TH) && (w_cur_gain != 2'd0)) begin
            r_gain[r_ptr]     <= w_cur_gain - 2'd1;
            r_stab_cnt[r_ptr] <= '0;
          end else if ((r_meas_pp < C_LOW_TH) && (w_cur_gain != 2'd3)) begin
            r_gain[r_ptr]     <= w_cur_gain + 2'd1;
            r_stab_cnt[r_ptr] <= '0;
          end else if (r_stab_cnt[r_ptr] != C_STABLE_N) begin
            r_stab_cnt[r_ptr] <= r_stab_cnt[r_ptr] + 2'd1;
          end
        end
        S_NEXT: begin
          r_ptr <= (r_ptr == C_LAST_CH) ? '0 : r_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign ch_gain[2*k+1:2*k] = r_gain[k];
    assign ch_stable[k]       = (r_stab_cnt[k] == C_STABLE_N);
  end

  assign mux_sel    = r_mux_sel;
  assign gain_ctrl  = r_gain_ctrl;
  assign meas_valid = r_meas_valid;
  assign meas_ch    = r_meas_ch;
  assign meas_pp    = r_meas_pp;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_agc_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_channel_scheduler
// Brief    : Visit-level reference model bench for agc_channel_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agc_channel_scheduler;
  localparam int NUM_CH = 4, CH_W = 2, SETTLE = 16, WIN = 256;
  localparam int OVER = 3941, LOW = 1791, HIGH = 3685, STN = 3;

  logic                adc_clk = 1'b0;
  logic                rst = 1'b1;
  logic [11:0]         adc_data = '0;
  logic                adc_valid = 1'b0;
  logic                enable = 1'b0;
  logic [CH_W-1:0]     mux_sel;
  logic [1:0]          gain_ctrl;
  logic [2*NUM_CH-1:0] ch_gain;
  logic [NUM_CH-1:0]   ch_stable;
  logic                meas_valid;
  logic [CH_W-1:0]     meas_ch;
  logic [11:0]         meas_pp;
  logic                busy;

  agc_channel_scheduler dut (
    .adc_clk(adc_clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .enable(enable), .mux_sel(mux_sel), .gain_ctrl(gain_ctrl), .ch_gain(ch_gain),
    .ch_stable(ch_stable), .meas_valid(meas_valid), .meas_ch(meas_ch),
    .meas_pp(meas_pp), .busy(busy)
  );

  always #5 adc_clk = ~adc_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_gain [NUM_CH];
  int m_cnt  [NUM_CH];
  bit m_stable [NUM_CH];
  int m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*NUM_CH-1:0] exp_gain_vec();
    logic [2*NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[2*k +: 2] = 2'(m_gain[k]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_stable_vec();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = m_stable[k];
    return v;
  endfunction

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_gain[k] = 0; m_cnt[k] = 0; m_stable[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mux_sel"},    mux_sel,    0);
    check_eq({tag, "_gain_ctrl"},  gain_ctrl,  0);
    check_eq({tag, "_ch_gain"},    ch_gain,    0);
    check_eq({tag, "_ch_stable"},  ch_stable,  0);
    check_eq({tag, "_meas_valid"}, meas_valid, 0);
    check_eq({tag, "_meas_ch"},    meas_ch,    0);
    check_eq({tag, "_meas_pp"},    meas_pp,    0);
    check_eq({tag, "_busy"},       busy,       0);
  endtask

  // Entered in the SELECT cycle of channel m_ptr. vmode: 0 every cycle, 1 random, 2 one-in-four.
  task automatic visit(input int lo, input int hi, input int ovl_at, input int vmode, input bit en_after);
    int ch, k, cyc, mx, mn, d, pp;
    bit ovl, early, v, done;
    done = 1'b0;
    while (!done) begin
      ch = m_ptr;
      early = 1'b0;
      check_eq("busy_select", busy, 1);
      for (int i = 0; i < SETTLE + 1; i++) begin
        adc_valid = 1'($urandom_range(0, 1));
        adc_data  = 12'($urandom_range(0, 4095));
        step();
        if (meas_valid) early = 1'b1;
        if (i == 0) begin
          check_eq("mux_sel", mux_sel, ch);
          check_eq("gain_ctrl", gain_ctrl, m_gain[ch]);
        end
      end
      if (!en_after) enable = 1'b0;
      k = 0; cyc = 0; mx = 0; mn = 4095; ovl = 1'b0;
      while (k < WIN && !ovl) begin
        if (cyc > 8 * WIN) begin
          check_eq("meas_timeout", cyc, 0);
          $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
          $finish;
        end
        case (vmode)
          0:       v = 1'b1;
          1:       v = 1'($urandom_range(0, 1));
          default: v = (cyc % 4 == 3);
        endcase
        if (v) begin
          if (k == ovl_at)  d = 4000;
          else if (k == 0)  d = lo;
          else if (k == 1)  d = hi;
          else              d = $urandom_range(lo, hi);
          if (d >= OVER && m_gain[ch] > 0) ovl = 1'b1;
          else begin
            if (d > mx) mx = d;
            if (d < mn) mn = d;
            k++;
          end
        end else begin
          d = $urandom_range(0, 4095);
        end
        adc_valid = v;
        adc_data  = 12'(d);
        if (meas_valid || mux_sel != 2'(ch)) early = 1'b1;
        step();
        cyc++;
      end
      adc_valid = 1'b0;
      check_eq("no_early_meas_valid", early, 0);
      if (ovl) begin
        m_gain[ch]--; m_cnt[ch] = 0; m_stable[ch] = 1'b0;
        check_eq("ovl_meas_valid", meas_valid, 0);
        check_eq("ovl_mux_sel", mux_sel, ch);
        check_eq("ovl_ch_gain", ch_gain, exp_gain_vec());
        check_eq("ovl_ch_stable", ch_stable, exp_stable_vec());
        ovl_at = -1;
      end else begin
        if (vmode == 2) check_eq("quarter_rate_cycles", cyc, 4 * WIN);
        pp = mx - mn;
        check_eq("meas_valid", meas_valid, 1);
        check_eq("meas_ch", meas_ch, ch);
        check_eq("meas_pp", meas_pp, pp);
        if (pp > HIGH && m_gain[ch] > 0) begin
          m_gain[ch]--; m_cnt[ch] = 0; m_stable[ch] = 1'b0;
        end else if (pp < LOW && m_gain[ch] < 3) begin
          m_gain[ch]++; m_cnt[ch] = 0; m_stable[ch] = 1'b0;
        end else begin
          if (m_cnt[ch] < STN) m_cnt[ch]++;
          if (m_cnt[ch] == STN) m_stable[ch] = 1'b1;
        end
        step();
        check_eq("next_meas_valid", meas_valid, 0);
        check_eq("ch_gain", ch_gain, exp_gain_vec());
        check_eq("ch_stable", ch_stable, exp_stable_vec());
        m_ptr = (m_ptr + 1) % NUM_CH;
        step();
        check_eq("busy_after_next", busy, en_after);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int lo, hi, ovl;
    model_reset();
    rst = 1'b1;
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_eq("idle_busy", busy, 0);
    enable = 1'b1;
    step();
    check_eq("select_busy", busy, 1);

    for (int s = 0; s < 6; s++) begin
      visit(1000, 3000, -1, 0, 1'b1);
      if (s == 0) visit(1800, 2300, -1, 0, 1'b1);
      else        visit(1500, 3000, -1, 0, 1'b1);
      if (s < 2)       visit(2000, 2200, -1, 0, 1'b1);
      else if (s == 2) visit(1200, 3000, 100, 0, 1'b1);
      else if (s == 5) visit(1200, 3000, WIN - 1, 0, 1'b1);
      else             visit(1200, 3000, -1, 1, 1'b1);
      visit(2000, 2100, -1, 0, 1'b1);
    end

    visit(1000, 3000, -1, 0, 1'b1);
    visit(1500, 3000, -1, 0, 1'b0);
    repeat (5) step();
    check_eq("idle_hold_busy", busy, 0);
    check_eq("idle_hold_mux", mux_sel, 1);
    enable = 1'b1;
    step();
    visit(500, 3400, -1, 2, 1'b1);

    for (int r = 0; r < 20; r++) begin
      lo  = $urandom_range(0, 3500);
      hi  = lo + $urandom_range(0, 3940 - lo);
      ovl = ($urandom_range(0, 3) == 0) ? $urandom_range(2, WIN - 1) : -1;
      visit(lo, hi, ovl, $urandom_range(0, 1), 1'b1);
    end

    repeat (4) step();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    enable = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    step();
    check_eq("post_rst_busy", busy, 0);
    enable = 1'b1;
    step();
    visit(1000, 3000, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/agc_channel_scheduler.md
Name: agc_channel_scheduler

Overview:
- Time-multiplexes one ADC and one relay gain stage across NUM_CH analog inputs.
- For each channel in round-robin order it:
  - selects the analog mux and applies that channel's stored relay gain code;
  - waits for relay and mux settling;
  - measures peak-to-peak over a sample window;
  - steps that channel's gain up or down by one.
- Sits between the ADC front end and the relay/mux drivers. It replaces the per-channel single-loop gain controller when several inputs share the converter.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.
- SETTLE_CYCLES, 16, adc_clk cycles to wait after a mux/gain change (>=1).
- WINDOW, 256, number of valid samples per measurement (>=2).
- OVER_TH, 3941, ADC code at or above which a sample counts as overload.
- LOW_TH, 1791, peak-to-peak below this means the gain is too small.
- HIGH_TH, 3685, peak-to-peak above this means the gain is too large.
- STABLE_N, 3, consecutive in-range measurements needed to set ch_stable (1..3).

Ports:
- adc_clk  in  1  sample-domain clock.
- rst  in  1  asynchronous reset, active-high.
- adc_data  in  12  unsigned ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- enable  in  1  run the scheduler.
- mux_sel  out  CH_W  analog mux channel select.
- gain_ctrl  out  2  relay code for the selected channel (0 = x3, 1 = x6.5, 2 = x13.5, 3 = x29.25).
- ch_gain  out  2*NUM_CH  packed per-channel gain codes; channel k occupies bits [2k+1:2k].
- ch_stable  out  NUM_CH  per-channel stable flags.
- meas_valid  out  1  one-cycle pulse when a measurement completes.
- meas_ch  out  CH_W  channel of the completed measurement.
- meas_pp  out  12  peak-to-peak of the completed measurement.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0. All channel gains 0, all stability counters 0, channel pointer 0, state IDLE.
- States: IDLE, SELECT, SETTLE, MEASURE, DECIDE, NEXT.
- IDLE:
  - If enable = 1, go to SELECT; otherwise stay.
  - The channel pointer is preserved across IDLE.
- SELECT (1 cycle):
  - mux_sel <= pointer; gain_ctrl <= ch_gain[pointer].
  - Clear the settle counter; go to SETTLE.
- SETTLE:
  - Count adc_clk cycles, ignoring adc_valid.
  - After exactly SETTLE_CYCLES cycles in SETTLE, go to MEASURE with peak = 0, valley = 0xFFF, sample count = 0.
- MEASURE:
  - On each adc_valid cycle, update peak/valley with adc_data and increment the sample count.
  - When the WINDOW-th valid sample is accepted, go to DECIDE. That sample is included in peak/valley.
- Overload in MEASURE:
  - Applies to a valid sample >= OVER_TH while the channel gain is > 0.
  - Takes priority over window completion on the same cycle.
  - Gain of this channel -= 1, its stability counter = 0, ch_stable bit = 0.
  - Go to SELECT on the same channel; no meas_valid is issued.
  - At gain 0, overload samples are treated as normal samples.
- DECIDE (1 cycle):
  - pp = peak - valley, 12-bit, never negative.
  - meas_valid = 1, meas_ch = pointer, meas_pp = pp.
  - If pp > HIGH_TH and gain > 0: gain -= 1, counter = 0, ch_stable bit = 0.
  - Else if pp < LOW_TH and gain < 3: gain += 1, counter = 0, ch_stable bit = 0.
  - Otherwise (in range, or out of range but saturated at gain 0 or 3): counter saturating-increment to STABLE_N; ch_stable bit = 1 when the counter reaches STABLE_N.
  - Go to NEXT.
- NEXT (1 cycle):
  - pointer = pointer + 1, wrapping NUM_CH-1 -> 0.
  - Go to SELECT if enable = 1, else IDLE.
- enable low during SELECT/SETTLE/MEASURE/DECIDE does not abort; the current channel completes, then the block goes to IDLE at NEXT.
- Per-channel latency with continuous adc_valid: 1 + SETTLE_CYCLES + WINDOW + 2 cycles (275 with defaults).
- mux_sel and gain_ctrl change only in SELECT. ch_gain updates become visible the cycle after DECIDE or after the overload sample.
- rst asserted at any time returns everything to reset values, including a partial measurement.

Test Plan:
- Reset, enable = 1, continuous valid, ch0 input alternating 1000/3000 -> SELECT at cycle 1; meas_valid at cycle 274 after leaving IDLE with meas_ch = 0, meas_pp = 2000; ch_gain[1:0] stays 0; after 3 sweeps ch_stable[0] = 1.
- ch1 at gain 0, input pp = 500 (1800/2300) -> DECIDE sets ch1 gain 1, ch_stable[1] = 0; next ch1 visit drives gain_ctrl = 1 during SETTLE.
- ch2 preset to gain 2, one sample 4000 mid-window -> ch2 gain 1, no meas_valid, mux_sel stays 2, new 16-cycle SETTLE starts, then a full 256-sample window.
- ch3 at gain 3, pp = 100 -> gain remains 3, meas_pp = 100, stability counter increments; ch_stable[3] = 1 after 3 visits.
- enable dropped during MEASURE of ch1 -> window completes, meas_valid for ch1, pointer becomes 2, IDLE, busy = 0; re-enable resumes at ch2.
- rst pulsed mid-SETTLE, and adc_valid toggled 1-of-4 cycles -> all outputs 0 immediately on rst; with 1-of-4 valid, the window takes 1024 cycles in MEASURE.
